r200_prefetch: RTL

//  Instruction prefetch buffer between instruction memory and the r200 fetch stage.

---
 rtl/r200_prefetch_if.sv | 27 ++
 rtl/r200_prefetch.sv | 93 +++++++++
 2 files changed

// File: rtl/r200_prefetch_if.sv
// Purpose: bundles the r200 prefetch memory port, redirect input and fetch-stage output.
// Latency: none, wires only.
// Backpressure: imem_gnt stalls issue; pop drains the head entry.
interface r200_prefetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pop;
    logic        out_valid;
    logic [31:0] out_instrn;
    logic [31:0] out_pc;
    logic [31:0] out_pcp4;

    modport master (
        output imem_req, imem_addr, out_valid, out_instrn, out_pc, out_pcp4,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, pop
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instrn, out_pc, out_pcp4,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, pop
    );
endinterface

// File: rtl/r200_prefetch.sv
// Purpose: sequential instruction prefetch FIFO with redirect flush and in-flight discard.
// Latency: response visible on out_* the cycle after rvalid; redirect -> req next cycle.
// Backpressure: issue only while FIFO entries plus outstanding requests stay below DEPTH.
module r200_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst_n,
    r200_prefetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_instrn_mem [DEPTH];
    logic [31:0]   r_pc_mem     [DEPTH];

    logic          w_req;
    logic          w_issue;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_outstanding_nxt;
    logic [31:0]   w_redirect_pc;

    // Credits cover both queued entries and requests still in flight, so a full FIFO never sees a response.
    assign w_inflight        = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req             = rst_n && (w_inflight < (CW+1)'(DEPTH)) && !bus.redirect;
    assign w_issue           = w_req && bus.imem_gnt;
    assign w_rsp             = bus.imem_rvalid && (r_outstanding != '0);
    assign w_drop            = w_rsp && (r_discard != '0);
    assign w_push            = w_rsp && (r_discard == '0);
    assign w_valid           = (r_count != '0);
    assign w_pop             = bus.pop && w_valid;
    assign w_outstanding_nxt = r_outstanding + CW'(w_issue) - CW'(w_rsp);
    assign w_redirect_pc     = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.out_valid  = w_valid;
    assign bus.out_instrn = w_valid ? r_instrn_mem[r_rd_ptr] : 32'h0;
    assign bus.out_pc     = w_valid ? r_pc_mem[r_rd_ptr] : 32'h0;
    assign bus.out_pcp4   = w_valid ? r_pc_mem[r_rd_ptr] + 32'd4 : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push && !bus.redirect) begin
            r_instrn_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pc_mem[r_wr_ptr]     <= r_resp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old stream.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_discard  <= w_outstanding_nxt;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                end
                if (w_pop)  r_rd_ptr  <= r_rd_ptr + AW'(1);
                if (w_drop) r_discard <= r_discard - CW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule
